// File: rtl/sd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : sd_cmd_sequencer
// Description : Register-bus master that issues one SD command, polls the
//               command interrupt status, reads the response and clears it.
// Revision    : 1.0 - initial release
// ============================================================================
module sd_cmd_sequencer #(
  parameter int CMD_W    = 16,
  parameter int POLL_GAP = 16,
  parameter int POLL_MAX = 4096
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [CMD_W-1:0] req_cmd,
  input  logic [31:0]      req_arg,
  input  logic             req_long,
  output logic             done,
  output logic [127:0]     resp,
  output logic [4:0]       status,
  output logic             timeout,
  output logic             we,
  output logic [6:0]       addr,
  output logic [7:0]       wdata,
  input  logic [7:0]       rdata
);

  localparam logic [6:0] c_addr_argument = 7'h00;
  localparam logic [6:0] c_addr_command  = 7'h04;
  localparam logic [6:0] c_addr_resp0    = 7'h08;
  localparam logic [6:0] c_addr_cmd_isr  = 7'h34;
  localparam int         c_gap_w         = $clog2(POLL_GAP + 1);
  localparam int         c_poll_w        = $clog2(POLL_MAX + 1);
  localparam logic [c_gap_w-1:0]  c_gap_last = c_gap_w'(POLL_GAP - 1);
  localparam logic [c_poll_w-1:0] c_poll_max = c_poll_w'(POLL_MAX);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_WR_CMD    = 3'd1,
    S_WR_ARG    = 3'd2,
    S_POLL_WAIT = 3'd3,
    S_POLL_RD   = 3'd4,
    S_RD_RESP   = 3'd5,
    S_CLR_ISR   = 3'd6,
    S_DONE      = 3'd7
  } state_t;

  state_t              r_state,   w_state_n;
  logic [3:0]          r_idx,     w_idx_n;
  logic [c_gap_w-1:0]  r_gap,     w_gap_n;
  logic [c_poll_w-1:0] r_poll,    w_poll_n;
  logic [15:0]         r_cmd,     w_cmd_n;
  logic [31:0]         r_arg,     w_arg_n;
  logic                r_long,    w_long_n;
  logic                r_ready,   w_ready_n;
  logic                r_done,    w_done_n;
  logic [127:0]        r_resp,    w_resp_n;
  logic [4:0]          r_status,  w_status_n;
  logic                r_timeout, w_timeout_n;
  logic                r_we,      w_we_n;
  logic [6:0]          r_addr,    w_addr_n;
  logic [7:0]          r_wdata,   w_wdata_n;

  logic [15:0]         w_cmd_in;
  logic [3:0]          w_idx_inc;
  logic [c_poll_w-1:0] w_poll_inc;
  logic [4:0]          w_isr;
  logic                w_unused;

  assign w_idx_inc  = r_idx + 4'd1;
  assign w_poll_inc = r_poll + 1'b1;
  assign w_isr      = rdata[4:0];
  assign w_unused   = &{1'b0, rdata[7:5]};

  // Bus outputs are computed for the upcoming cycle and registered, so the
  // registered addr always names the byte being accessed in the current state.
  always_comb begin
    w_state_n   = r_state;
    w_idx_n     = r_idx;
    w_gap_n     = r_gap;
    w_poll_n    = r_poll;
    w_cmd_n     = r_cmd;
    w_arg_n     = r_arg;
    w_long_n    = r_long;
    w_done_n    = 1'b0;
    w_resp_n    = r_resp;
    w_status_n  = r_status;
    w_timeout_n = r_timeout;
    w_we_n      = 1'b0;
    w_addr_n    = 7'h00;
    w_wdata_n   = 8'h00;
    w_cmd_in    = '0;
    w_cmd_in[CMD_W-1:0] = req_cmd;

    case (r_state)
      S_IDLE: begin
        if (req_valid && r_ready) begin
          w_state_n   = S_WR_CMD;
          w_idx_n     = 4'd0;
          w_poll_n    = '0;
          w_cmd_n     = w_cmd_in;
          w_arg_n     = req_arg;
          w_long_n    = req_long;
          w_resp_n    = '0;
          w_status_n  = '0;
          w_timeout_n = 1'b0;
          w_we_n      = 1'b1;
          w_addr_n    = c_addr_command;
          w_wdata_n   = w_cmd_in[7:0];
        end
      end
      S_WR_CMD: begin
        w_we_n = 1'b1;
        if (r_idx == 4'd1) begin
          w_state_n = S_WR_ARG;
          w_idx_n   = 4'd0;
          w_addr_n  = c_addr_argument;
          w_wdata_n = r_arg[7:0];
        end else begin
          w_idx_n   = w_idx_inc;
          w_addr_n  = c_addr_command + 7'd1;
          w_wdata_n = r_cmd[15:8];
        end
      end
      S_WR_ARG: begin
        if (r_idx == 4'd3) begin
          w_state_n = S_POLL_WAIT;
          w_gap_n   = '0;
        end else begin
          w_we_n    = 1'b1;
          w_idx_n   = w_idx_inc;
          w_addr_n  = c_addr_argument + {5'd0, w_idx_inc[1:0]};
          w_wdata_n = r_arg[{w_idx_inc[1:0], 3'b000} +: 8];
        end
      end
      S_POLL_WAIT: begin
        if (r_gap == c_gap_last) begin
          w_state_n = S_POLL_RD;
          w_addr_n  = c_addr_cmd_isr;
        end else begin
          w_gap_n = r_gap + 1'b1;
        end
      end
      S_POLL_RD: begin
        w_status_n = w_isr;
        w_poll_n   = w_poll_inc;
        if (w_isr != 5'd0) begin
          w_state_n = S_RD_RESP;
          w_idx_n   = 4'd0;
          w_addr_n  = c_addr_resp0;
        end else if (w_poll_inc == c_poll_max) begin
          w_timeout_n = 1'b1;
          w_state_n   = S_CLR_ISR;
          w_we_n      = 1'b1;
          w_addr_n    = c_addr_cmd_isr;
        end else begin
          w_state_n = S_POLL_WAIT;
          w_gap_n   = '0;
        end
      end
      S_RD_RESP: begin
        w_resp_n[{r_idx, 3'b000} +: 8] = rdata;
        if (r_idx == (r_long ? 4'd15 : 4'd3)) begin
          w_state_n = S_CLR_ISR;
          w_we_n    = 1'b1;
          w_addr_n  = c_addr_cmd_isr;
        end else begin
          w_idx_n  = w_idx_inc;
          w_addr_n = c_addr_resp0 + {3'd0, w_idx_inc};
        end
      end
      S_CLR_ISR: begin
        w_state_n = S_DONE;
        w_done_n  = 1'b1;
      end
      S_DONE: begin
        w_state_n = S_IDLE;
      end
      default: begin
        w_state_n = S_IDLE;
      end
    endcase

    w_ready_n = (w_state_n == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_idx     <= 4'd0;
      r_gap     <= '0;
      r_poll    <= '0;
      r_cmd     <= 16'h0000;
      r_arg     <= 32'h0;
      r_long    <= 1'b0;
      r_ready   <= 1'b1;
      r_done    <= 1'b0;
      r_resp    <= '0;
      r_status  <= 5'd0;
      r_timeout <= 1'b0;
      r_we      <= 1'b0;
      r_addr    <= 7'h00;
      r_wdata   <= 8'h00;
    end else begin
      r_state   <= w_state_n;
      r_idx     <= w_idx_n;
      r_gap     <= w_gap_n;
      r_poll    <= w_poll_n;
      r_cmd     <= w_cmd_n;
      r_arg     <= w_arg_n;
      r_long    <= w_long_n;
      r_ready   <= w_ready_n;
      r_done    <= w_done_n;
      r_resp    <= w_resp_n;
      r_status  <= w_status_n;
      r_timeout <= w_timeout_n;
      r_we      <= w_we_n;
      r_addr    <= w_addr_n;
      r_wdata   <= w_wdata_n;
    end
  end

  assign req_ready = r_ready;
  assign done      = r_done;
  assign resp      = r_resp;
  assign status    = r_status;
  assign timeout   = r_timeout;
  assign we        = r_we;
  assign addr      = r_addr;
  assign wdata     = r_wdata;

endmodule
`default_nettype wire

// File: tb/tb_sd_cmd_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sd_cmd_sequencer
// Description : Directed bench for sd_cmd_sequencer with a register-file model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sd_cmd_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_ready;
  logic [15:0]  req_cmd = 16'h0;
  logic [31:0]  req_arg = 32'h0;
  logic         req_long = 1'b0;
  logic         done;
  logic [127:0] resp;
  logic [4:0]   status;
  logic         timeout;
  logic         we;
  logic [6:0]   addr;
  logic [7:0]   wdata;
  logic [7:0]   rdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int polls = 0;
  int cpl_at = 0;
  logic [7:0] isr_val = 8'h00;
  logic [7:0] mem [0:127];
  logic [14:0] wlog[$];
  logic [6:0]  rlog[$];
  int poll_cyc[$];
  int acc_cyc = 0;
  int done_cyc = 0;

  sd_cmd_sequencer #(.CMD_W(16), .POLL_GAP(16), .POLL_MAX(4)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_cmd(req_cmd), .req_arg(req_arg), .req_long(req_long), .done(done),
    .resp(resp), .status(status), .timeout(timeout), .we(we), .addr(addr),
    .wdata(wdata), .rdata(rdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // The interrupt status reads as isr_val from the cpl_at-th poll onwards.
  assign rdata = (addr == 7'h34) ? ((cpl_at != 0 && polls >= cpl_at) ? isr_val : 8'h00)
                                 : mem[addr];

  always @(negedge clk) begin
    if (!rst) begin
      if (we) wlog.push_back({addr, wdata});
      else if (addr == 7'h34) begin
        polls = polls + 1;
        poll_cyc.push_back(cyc);
      end else if (addr >= 7'h08 && addr <= 7'h17) rlog.push_back(addr);
    end
  end

  task automatic set_resp(input logic [31:0] r0, r1, r2, r3);
    logic [31:0] w [4];
    w[0] = r0; w[1] = r1; w[2] = r2; w[3] = r3;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        mem[8 + 4*i + j] = w[i][8*j +: 8];
  endtask

  // Called at a negedge; returns #1 after the accepting edge.
  task automatic start_req(input logic [15:0] cmd, input logic [31:0] arg, input logic lng);
    req_cmd = cmd; req_arg = arg; req_long = lng; req_valid = 1'b1;
    wlog.delete(); rlog.delete(); poll_cyc.delete(); polls = 0;
    for (int k = 0; k < 50 && !req_ready; k++) @(negedge clk);
    if (!req_ready) begin
      errors++;
      $display("FAIL start_ready: req_ready got %b want 1", req_ready);
    end
    @(posedge clk);
    #1;
    acc_cyc = cyc;
    req_valid = 1'b0; req_cmd = 16'hFFFF; req_arg = 32'hFFFFFFFF; req_long = 1'b1;
  endtask

  task automatic wait_done(output int lat);
    lat = -1;
    for (int k = 1; k <= 400; k++) begin
      @(negedge clk);
      if (done) begin
        lat = k;
        done_cyc = cyc;
        break;
      end
    end
    if (lat < 0) begin
      errors++;
      $display("FAIL done_timeout: no done within 400 cycles");
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if ({req_ready, we, addr, wdata, done, timeout, status} !== {1'b1, 1'b0, 7'h00, 8'h00, 1'b0, 1'b0, 5'h00}) begin
      errors++;
      $display("FAIL reset_outputs: got rdy=%b we=%b addr=%h wdata=%h done=%b to=%b st=%h want 1 0 00 00 0 0 00",
               req_ready, we, addr, wdata, done, timeout, status);
    end
    checks++;
    if (resp !== 128'h0) begin errors++; $display("FAIL reset_resp: got %h want 0", resp); end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_short();
    int lat;
    logic [14:0] exp_w [7];
    exp_w[0] = {7'h04, 8'h19}; exp_w[1] = {7'h05, 8'h01}; exp_w[2] = {7'h00, 8'hEF};
    exp_w[3] = {7'h01, 8'hBE}; exp_w[4] = {7'h02, 8'hAD}; exp_w[5] = {7'h03, 8'hDE};
    exp_w[6] = {7'h34, 8'h00};
    set_resp(32'h00000900, 32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC);
    isr_val = 8'h01; cpl_at = 1;
    start_req(16'h0119, 32'hDEADBEEF, 1'b0);
    req_valid = 1'b1;  // must be ignored while busy
    wait_done(lat);
    req_valid = 1'b0;
    checks++;
    if (lat !== 29) begin errors++; $display("FAIL short_latency: got %0d want 29", lat); end
    checks++;
    if (wlog.size() !== 7) begin errors++; $display("FAIL short_wr_count: got %0d want 7", wlog.size()); end
    for (int i = 0; i < 7 && i < wlog.size(); i++) begin
      checks++;
      if (wlog[i] !== exp_w[i]) begin
        errors++;
        $display("FAIL short_wr_%0d: got %h:%h want %h:%h", i, wlog[i][14:8], wlog[i][7:0], exp_w[i][14:8], exp_w[i][7:0]);
      end
    end
    checks++;
    if (rlog.size() !== 4) begin errors++; $display("FAIL short_rd_count: got %0d want 4", rlog.size()); end
    checks++;
    if (resp !== 128'h900) begin errors++; $display("FAIL short_resp: got %h want 900", resp); end
    checks++;
    if (status !== 5'h01 || timeout !== 1'b0) begin
      errors++; $display("FAIL short_status: got st=%h to=%b want 01 0", status, timeout);
    end
    checks++;
    if (polls !== 1) begin errors++; $display("FAIL short_polls: got %0d want 1", polls); end
    @(negedge clk);
    checks++;
    if (done !== 1'b0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL short_done_pulse: got done=%b rdy=%b want 0 1", done, req_ready);
    end
    repeat (3) @(negedge clk);
    checks++;
    if (wlog.size() !== 7) begin errors++; $display("FAIL short_busy_ignored: got %0d writes want 7", wlog.size()); end
  endtask

  task automatic test_long();
    int lat;
    set_resp(32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444);
    isr_val = 8'h01; cpl_at = 1;
    start_req(16'h0202, 32'h00000000, 1'b1);
    wait_done(lat);
    checks++;
    if (lat !== 41) begin errors++; $display("FAIL long_latency: got %0d want 41", lat); end
    checks++;
    if (resp !== 128'h44444444_33333333_22222222_11111111) begin
      errors++; $display("FAIL long_resp: got %h want 44444444333333332222222211111111", resp);
    end
    checks++;
    if (rlog.size() !== 16) begin errors++; $display("FAIL long_rd_count: got %0d want 16", rlog.size()); end
    for (int i = 0; i < 16 && i < rlog.size(); i++) begin
      checks++;
      if (rlog[i] !== 7'(8 + i)) begin errors++; $display("FAIL long_rd_addr_%0d: got %h want %h", i, rlog[i], 8 + i); end
    end
    checks++;
    if (wlog.size() !== 7 || wlog[wlog.size()-1] !== {7'h34, 8'h00}) begin
      errors++; $display("FAIL long_clear: got %0d writes last %h want 7 writes last 3400", wlog.size(), wlog[wlog.size()-1]);
    end
    @(negedge clk);
  endtask

  task automatic test_slow();
    int lat;
    set_resp(32'h00000900, 32'h0, 32'h0, 32'h0);
    isr_val = 8'h01; cpl_at = 3;
    start_req(16'h0119, 32'h12345678, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== 63) begin errors++; $display("FAIL slow_latency: got %0d want 63", lat); end
    checks++;
    if (polls !== 3) begin errors++; $display("FAIL slow_polls: got %0d want 3", polls); end
    for (int i = 1; i < 3 && i < poll_cyc.size(); i++) begin
      checks++;
      if (poll_cyc[i] - poll_cyc[i-1] !== 17) begin
        errors++; $display("FAIL slow_gap_%0d: got %0d want 17", i, poll_cyc[i] - poll_cyc[i-1]);
      end
    end
    checks++;
    if (status !== 5'h01 || resp !== 128'h900) begin
      errors++; $display("FAIL slow_result: got st=%h resp=%h want 01 900", status, resp);
    end
    @(negedge clk);
  endtask

  task automatic test_timeout();
    int lat;
    set_resp(32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888);
    isr_val = 8'h01; cpl_at = 0;
    start_req(16'h0119, 32'hCAFEF00D, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== 76) begin errors++; $display("FAIL to_latency: got %0d want 76", lat); end
    checks++;
    if (polls !== 4) begin errors++; $display("FAIL to_polls: got %0d want 4", polls); end
    checks++;
    if (rlog.size() !== 0) begin errors++; $display("FAIL to_no_reads: got %0d want 0", rlog.size()); end
    checks++;
    if (timeout !== 1'b1 || status !== 5'h00 || resp !== 128'h0) begin
      errors++; $display("FAIL to_result: got to=%b st=%h resp=%h want 1 00 0", timeout, status, resp);
    end
    checks++;
    if (wlog.size() !== 7 || wlog[wlog.size()-1] !== {7'h34, 8'h00}) begin
      errors++; $display("FAIL to_clear: got %0d writes last %h want 7 writes last 3400", wlog.size(), wlog[wlog.size()-1]);
    end
    @(negedge clk);
  endtask

  task automatic test_error();
    int lat;
    set_resp(32'h12345678, 32'h9ABCDEF0, 32'h0, 32'h0);
    isr_val = 8'h02; cpl_at = 1;
    start_req(16'h0305, 32'h00000001, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== 29) begin errors++; $display("FAIL err_latency: got %0d want 29", lat); end
    checks++;
    if (status !== 5'h02 || timeout !== 1'b0) begin
      errors++; $display("FAIL err_status: got st=%h to=%b want 02 0", status, timeout);
    end
    checks++;
    if (rlog.size() !== 4 || resp !== 128'h12345678) begin
      errors++; $display("FAIL err_resp: got %0d reads resp=%h want 4 12345678", rlog.size(), resp);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back();
    int lat;
    set_resp(32'h00000900, 32'h0, 32'h0, 32'h0);
    isr_val = 8'h01; cpl_at = 1;
    start_req(16'h0111, 32'h01020304, 1'b0);
    wait_done(lat);
    start_req(16'h0222, 32'hA0B0C0D0, 1'b0);
    checks++;
    if (acc_cyc - done_cyc !== 2) begin
      errors++; $display("FAIL b2b_accept: got %0d edges after done want 2", acc_cyc - done_cyc);
    end
    wait_done(lat);
    checks++;
    if (lat !== 29) begin errors++; $display("FAIL b2b_latency: got %0d want 29", lat); end
    checks++;
    if (wlog.size() !== 7 || wlog[0] !== {7'h04, 8'h22} || wlog[2] !== {7'h00, 8'hD0} || wlog[5] !== {7'h03, 8'hA0}) begin
      errors++; $display("FAIL b2b_writes: got n=%0d w0=%h w2=%h w5=%h want 7 0422 00d0 03a0",
                         wlog.size(), wlog[0], wlog[2], wlog[5]);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    int lat;
    set_resp(32'h00000900, 32'h0, 32'h0, 32'h0);
    isr_val = 8'h01; cpl_at = 1;
    start_req(16'h0119, 32'hDEADBEEF, 1'b0);
    repeat (4) @(negedge clk);
    checks++;
    if ({we, addr, wdata} !== {1'b1, 7'h01, 8'hBE}) begin
      errors++; $display("FAIL rmid_pre: got we=%b addr=%h wdata=%h want 1 01 be", we, addr, wdata);
    end
    #1 rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({we, req_ready, addr, wdata, done} !== {1'b0, 1'b1, 7'h00, 8'h00, 1'b0}) begin
      errors++; $display("FAIL rmid_reset: got we=%b rdy=%b addr=%h wdata=%h done=%b want 0 1 00 00 0",
                         we, req_ready, addr, wdata, done);
    end
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (wlog.size() !== 4) begin errors++; $display("FAIL rmid_no_clear: got %0d writes want 4", wlog.size()); end
    start_req(16'h0119, 32'hDEADBEEF, 1'b0);
    wait_done(lat);
    checks++;
    if (lat !== 29 || resp !== 128'h900 || status !== 5'h01 || wlog.size() !== 7) begin
      errors++; $display("FAIL rmid_recover: got lat=%0d resp=%h st=%h n=%0d want 29 900 01 7",
                         lat, resp, status, wlog.size());
    end
    @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 128; i++) mem[i] = 8'h00;
    test_reset();
    test_short();
    test_long();
    test_slow();
    test_timeout();
    test_error();
    test_back_to_back();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
